// File: rtl/axis_i2s_rx_deser_if.sv
// AXI-Stream bundle carrying one I2S channel word per beat.
// last marks the right-channel word that closes a stereo frame.
interface axis_i2s_rx_deser_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  last;

  modport master (output data, valid, last, input ready);
  modport slave  (input data, valid, last, output ready);
endinterface

// File: rtl/axis_i2s_rx_deser.sv
// I2S receive deserializer -> AXI-Stream master.
// The codec-driven SCLK/LRCK/SDIN are synchronized into axis_clk and MSB-first words are
// captured one bit after each LRCK transition. Words leave as left (last=0) / right (last=1)
// pairs through a small FIFO. A left word is only accepted when the FIFO can also hold its
// right partner, so a frame is either stored whole or dropped whole.
// Optional feature macro: RX_DROP_CNT_EN enables the saturating dropped-frame counter;
// without it drop_count is tied to zero.
module axis_i2s_rx_deser #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_BITS  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       axis_clk,
  input  logic                       axis_resetn,
  input  logic                       i2s_sclk,
  input  logic                       i2s_lrck,
  input  logic                       i2s_sdin,
  axis_i2s_rx_deser_if.master        m_axis,
  output logic                       overflow,
  output logic [15:0]                drop_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(SLOT_BITS);

  typedef enum logic [1:0] {WAIT_LEFT, SKIP, SHIFT, TAIL} state_t;

  logic [1:0] sclk_sync, lrck_sync, sdin_sync;
  logic       sclk_prev, lrck_prev;
  logic       sclk_rise, lrck_now, sdin_now, lrck_edge;

  state_t                state, state_nx;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-2:0] shreg;      // all bits but the last; the last comes straight from sdin
  logic                  channel;    // 0 = left, 1 = right
  logic                  drop_pair;  // left of this frame was dropped, drop the right too
  logic                  word_done, abort, fifo_tight, drop_left, keep_word;

  logic                  push_pend, push_last;
  logic [DATA_WIDTH-1:0] push_word;

  logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
  logic [DATA_WIDTH:0]   head;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  fifo_valid, pop;

  assign sclk_rise = sclk_sync[1] & ~sclk_prev;
  assign lrck_now  = lrck_sync[1];
  assign sdin_now  = sdin_sync[1];
  assign lrck_edge = sclk_rise & (lrck_now != lrck_prev);

  // Two-flop synchronizers of equal depth keep sdin/lrck aligned with the sclk edge detect
  always_ff @(posedge axis_clk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      sclk_sync <= '0;
      lrck_sync <= '0;
      sdin_sync <= '0;
      sclk_prev <= 1'b0;
      lrck_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], i2s_sclk};
      lrck_sync <= {lrck_sync[0], i2s_lrck};
      sdin_sync <= {sdin_sync[0], i2s_sdin};
      sclk_prev <= sclk_sync[1];
      if (sclk_rise) lrck_prev <= lrck_now;
    end
  end

  // Framing state register
  always_ff @(posedge axis_clk or negedge axis_resetn) begin
    if (!axis_resetn) state <= WAIT_LEFT;
    else              state <= state_nx;
  end

  // Next state plus word completion / pair admission decisions
  always_comb begin
    state_nx  = state;
    word_done = 1'b0;
    abort     = 1'b0;
    if (sclk_rise) begin
      case (state)
        WAIT_LEFT: if (lrck_edge && !lrck_now) state_nx = SKIP;
        // The rise leaving SKIP carries the MSB (one bit after the LRCK change)
        SKIP: begin
          if (lrck_edge) begin
            abort    = 1'b1;
            state_nx = WAIT_LEFT;
          end else begin
            state_nx = SHIFT;
          end
        end
        SHIFT: begin
          if (lrck_edge) begin
            abort    = 1'b1;
            state_nx = WAIT_LEFT;
          end else if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
            word_done = 1'b1;
            state_nx  = TAIL;
          end
        end
        TAIL:    if (lrck_edge) state_nx = SKIP;
        default: state_nx = WAIT_LEFT;
      endcase
    end
    // Pops only ever free space, so checking for two free entries at the left word is
    // enough to guarantee the right word a slot later.
    fifo_tight = count > CW'(FIFO_DEPTH - 2);
    drop_left  = word_done && !channel && fifo_tight;
    keep_word  = word_done && (channel ? !drop_pair : !fifo_tight);
  end

  // Shift register, bit counter, channel tracking, pair-drop bookkeeping
  always_ff @(posedge axis_clk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      channel   <= 1'b0;
      drop_pair <= 1'b0;
      overflow  <= 1'b0;
      push_pend <= 1'b0;
      push_word <= '0;
      push_last <= 1'b0;
    end else begin
      push_pend <= keep_word;
      if (word_done) begin
        push_word <= {shreg, sdin_now};
        push_last <= channel;
      end
      if (sclk_rise) begin
        case (state)
          WAIT_LEFT: channel <= 1'b0;
          SKIP: begin
            shreg   <= {shreg[DATA_WIDTH-3:0], sdin_now};
            bit_cnt <= BW'(1);
          end
          SHIFT: begin
            shreg   <= {shreg[DATA_WIDTH-3:0], sdin_now};
            bit_cnt <= bit_cnt + BW'(1);
          end
          TAIL:    if (lrck_edge) channel <= lrck_now;
          default: ;
        endcase
      end
      if (abort)                      drop_pair <= 1'b0;
      else if (word_done && channel)  drop_pair <= 1'b0;
      else if (drop_left)             drop_pair <= 1'b1;
      if (drop_left) overflow <= 1'b1;
    end
  end

`ifdef RX_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  // Saturating count of whole stereo frames lost to a full FIFO
  always_ff @(posedge axis_clk or negedge axis_resetn) begin
    if (!axis_resetn)                            drop_cnt_q <= '0;
    else if (drop_left && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
  end
  assign drop_count = drop_cnt_q;
`else
  assign drop_count = 16'h0000;
`endif

  assign fifo_valid = (count != '0);
  assign pop        = fifo_valid && m_axis.ready;

  // FIFO pointers and occupancy; simultaneous push and pop both take effect
  always_ff @(posedge axis_clk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_pend) wr_ptr <= wr_ptr + AW'(1);
      if (pop)       rd_ptr <= rd_ptr + AW'(1);
      case ({push_pend, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: outputs are gated by occupancy
  always_ff @(posedge axis_clk) begin
    if (push_pend) mem[wr_ptr] <= {push_last, push_word};
  end

  assign head         = mem[rd_ptr];
  assign m_axis.valid = fifo_valid;
  assign m_axis.data  = fifo_valid ? head[DATA_WIDTH-1:0] : '0;
  assign m_axis.last  = fifo_valid & head[DATA_WIDTH];
endmodule

// File: tb/tb_axis_i2s_rx_deser.sv
// Bench for axis_i2s_rx_deser: a standard I2S source (MSB one SCLK after LRCK change,
// random filler bits) feeds the DUT; a frame-level model predicts the beat stream.
module tb_axis_i2s_rx_deser;
  localparam int DW    = 24;
  localparam int SLOT  = 32;
  localparam int DEPTH = 4;

  logic        clk = 1'b0, resetn = 1'b0;
  logic        sclk = 1'b0, lrck = 1'b0, sdin = 1'b0;
  logic        overflow;
  logic [15:0] drop_count;

  axis_i2s_rx_deser_if #(.DATA_WIDTH(DW)) bus ();

  axis_i2s_rx_deser #(.DATA_WIDTH(DW), .SLOT_BITS(SLOT), .FIFO_DEPTH(DEPTH)) dut (
    .axis_clk   (clk),
    .axis_resetn(resetn),
    .i2s_sclk   (sclk),
    .i2s_lrck   (lrck),
    .i2s_sdin   (sdin),
    .m_axis     (bus),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int          errors = 0, checks = 0;
  logic [DW:0] exp_q[$];
  logic        m_ovf = 1'b0;
  int          m_drops = 0;
  logic        prev_stall = 1'b0;
  logic [DW:0] prev_word = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] exp_drops();
`ifdef RX_DROP_CNT_EN
    return (m_drops > 65535) ? 32'hFFFF : 32'(m_drops);
`else
    return 32'h0;
`endif
  endfunction

  // One SCLK period: data and word select change on the falling edge
  task automatic send_bit(input logic lr, input logic d);
    sclk = 1'b0; lrck = lr; sdin = d;
    #40;
    sclk = 1'b1;
    #40;
  endtask

  task automatic send_junk(input logic lr, input int n);
    for (int i = 0; i < n; i++) send_bit(lr, 1'($urandom));
  endtask

  // Full stereo frame; when record is set the model admits the pair only if two FIFO
  // entries are free at the end of the left word.
  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit record);
    logic [DW-1:0] w;
    bit            drop;
    drop = 1'b0;
    for (int ch = 0; ch < 2; ch++) begin
      w = (ch == 0) ? l : r;
      send_bit(1'(ch), 1'($urandom));
      for (int i = DW - 1; i >= 0; i--) send_bit(1'(ch), w[i]);
      if (record) begin
        if (ch == 0) begin
          if (exp_q.size() <= DEPTH - 2) exp_q.push_back({1'b0, w});
          else begin
            drop = 1'b1;
            m_ovf = 1'b1;
            m_drops++;
          end
        end else if (!drop) begin
          exp_q.push_back({1'b1, w});
        end
      end
      send_junk(1'(ch), SLOT - DW - 1);
    end
  endtask

  task automatic send_rand_frame(input bit record);
    send_frame(DW'($urandom), DW'($urandom), record);
  endtask

  task automatic toggle_ready(input int n);
    repeat (n) begin
      @(posedge clk); #2;
      bus.ready = ~bus.ready;
    end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #2;
    chk({tag, "_idle_valid"}, 32'(bus.valid), 32'd0);
  endtask

  // Beat scoreboard and AXIS stability monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!resetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.valid), 32'd1);
        chk("stall_word", 32'({bus.last, bus.data}), 32'(prev_word));
      end
      if (bus.valid && bus.ready) begin
        chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("beat", 32'({bus.last, bus.data}), 32'(exp_q.pop_front()));
      end
      prev_stall = bus.valid && !bus.ready;
      prev_word  = {bus.last, bus.data};
    end
  end

  initial begin
    bus.ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_data", 32'(bus.data), 32'd0);
    chk("rst_last", 32'(bus.last), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_drop_count", 32'(drop_count), 32'd0);
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    // Start mid-left then mid-right: nothing until the first complete left word
    bus.ready = 1'b1;
    send_junk(1'b0, 10);
    send_junk(1'b1, 12);
    send_frame(24'hA5A5A5, 24'h5A5A5A, 1'b1);
    wait_drain("first_frame");

    // Left word cut short after 10 bits: discarded, next frame clean
    send_bit(1'b0, 1'($urandom));
    send_junk(1'b0, 10);
    send_junk(1'b1, SLOT);
    send_rand_frame(1'b1);
    wait_drain("short_word");

    // Two frames queued, then ready toggling every cycle while draining and receiving
    bus.ready = 1'b0;
    send_rand_frame(1'b1);
    send_rand_frame(1'b1);
    fork
      begin send_rand_frame(1'b1); send_rand_frame(1'b1); end
      toggle_ready(1400);
    join
    bus.ready = 1'b1;
    wait_drain("toggle_ready");
    chk("no_overflow_yet", 32'(overflow), 32'(m_ovf));

    // Stalled for three frames: third frame dropped whole
    bus.ready = 1'b0;
    send_rand_frame(1'b1);
    send_rand_frame(1'b1);
    send_rand_frame(1'b1);
    chk("ovf_set", 32'(overflow), 32'(m_ovf));
    chk("ovf_model", 32'(m_ovf), 32'd1);
    chk("drop_count", 32'(drop_count), exp_drops());
    chk("full_valid", 32'(bus.valid), 32'd1);
    chk("full_head_last", 32'(bus.last), 32'd0);
    bus.ready = 1'b1;
    wait_drain("overflow");
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Reset mid-SHIFT with two words queued
    bus.ready = 1'b0;
    send_rand_frame(1'b1);
    fork
      send_rand_frame(1'b0);
      begin
        #1120;
        resetn = 1'b0;
        exp_q.delete();
        m_ovf = 1'b0;
        m_drops = 0;
        #1;
        chk("mid_rst_valid", 32'(bus.valid), 32'd0);
        chk("mid_rst_data", 32'(bus.data), 32'd0);
        chk("mid_rst_overflow", 32'(overflow), 32'd0);
        chk("mid_rst_drop_count", 32'(drop_count), 32'd0);
        #29;
        resetn = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #2;
    chk("post_rst_empty", 32'(bus.valid), 32'd0);
    bus.ready = 1'b1;
    send_rand_frame(1'b1);
    wait_drain("after_reset");
    chk("post_rst_overflow", 32'(overflow), 32'(m_ovf));
    chk("post_rst_drop_count", 32'(drop_count), exp_drops());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
